// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial adder/subtractor.
// Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, least-significant
// chunk first, using a ripple carry that is held in a register between cycles.
// Result valid NCHUNK edges after acceptance; result is held until out_ready.
// Back-to-back throughput is one operation every NCHUNK+2 cycles.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      operand handshake (op, a, b)
//   out_valid/out_ready    result handshake (sum, cout, ovf, zero, neg)
//   op                     0 = a+b, 1 = a-b (computed as a + ~b + 1)
//   cout                   carry out of bit WIDTH-1 (subtract: 1 = no borrow)
//   ovf                    signed two's-complement overflow
//   zero, neg              derived from the final (possibly clamped) sum
//
// Optional feature macro: ADDSUB_SATURATE_EN
//   When defined, an overflowing result is clamped to the signed limit in the
//   direction of a's sign. ovf and cout still report the unclamped condition.

module addsub_serial #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;     // b already inverted for subtract
   logic             carry;   // ripple carry between chunks
   logic [CW-1:0]    cnt;     // index of the chunk processed this cycle

   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK-1:0] res_chunk;
   logic             carry_nxt;
   logic             msb_cin;
   logic             ovf_nxt;
   logic             last;
   logic [WIDTH-1:0] sum_nxt;
   logic [WIDTH-1:0] sum_fin;
   int               idx;

   // Ready only in IDLE and never while reset is asserted.
   assign in_ready = (state == S_IDLE) && !rst;

   assign last = (cnt == CW'(NCHUNK - 1));

   always_comb begin
      idx       = int'(cnt) * CHUNK;
      a_chunk   = a_q[idx +: CHUNK];
      b_chunk   = b_q[idx +: CHUNK];
      {carry_nxt, res_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk}
                             + {{CHUNK{1'b0}}, carry};
      // Carry into the top bit of the chunk recovered from sum = a ^ b ^ cin.
      // Only meaningful on the last chunk, where it is the carry into bit WIDTH-1.
      msb_cin   = res_chunk[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
      ovf_nxt   = msb_cin ^ carry_nxt;
      sum_nxt   = sum;
      sum_nxt[idx +: CHUNK] = res_chunk;
      sum_fin   = sum_nxt;
`ifdef ADDSUB_SATURATE_EN
      // Overflow always drives the result away from a's sign, so clamp towards it.
      if (ovf_nxt) begin
         sum_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

   // Operand registers are not reset: they are always reloaded before use.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         carry     <= 1'b0;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
         neg       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= op ? ~b : b;
                  carry <= op;           // the +1 of two's-complement subtract
                  cnt   <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               carry <= carry_nxt;
               if (last) begin
                  sum       <= sum_fin;
                  cout      <= carry_nxt;
                  ovf       <= ovf_nxt;
                  zero      <= (sum_fin == '0);
                  neg       <= sum_fin[WIDTH-1];
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  sum <= sum_nxt;
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_serial.sv
// Testbench for addsub_serial (WIDTH=16, CHUNK=4): directed test-plan cases plus
// random operations checked against a plain-arithmetic reference model.

module tb_addsub_serial;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        op;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;
   logic        zero;
   logic        neg;

   int total = 0;
   int bad   = 0;

   addsub_serial #(.WIDTH(16), .CHUNK(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero),
      .neg       (neg)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: whole-word arithmetic with a 17-bit intermediate.
   task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mop,
                        output logic [15:0] s, output logic c, output logic v,
                        output logic z, output logic n);
      logic [16:0] r;
      if (mop) r = {1'b0, ma} - {1'b0, mb} + 17'h10000;
      else     r = {1'b0, ma} + {1'b0, mb};
      s = r[15:0];
      c = r[16];
      if (mop) v = (ma[15] != mb[15]) && (s[15] != ma[15]);
      else     v = (ma[15] == mb[15]) && (s[15] != ma[15]);
`ifdef ADDSUB_SATURATE_EN
      if (v) s = ma[15] ? 16'h8000 : 16'h7FFF;
`endif
      z = (s == 16'h0000);
      n = s[15];
   endtask

   // One full operation; 'hold' cycles of out_ready=0 after out_valid, with a
   // stray in_valid pulse during the hold that must be ignored.
   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic top,
                        input int hold);
      logic [15:0] es;
      logic ec, ev, ez, en;
      int n;
      model(ta, tb, top, es, ec, ev, ez, en);
      n = 0;
      while (!in_ready && n < 20) begin tick(); n++; end
      chk("in_ready_before_op", 32'(in_ready), 32'd1);
      a = ta; b = tb; op = top; in_valid = 1'b1;
      tick();                                     // acceptance edge
      in_valid = 1'b0;
      a = 16'hDEAD; b = 16'hBEEF; op = ~top;      // inputs must already be latched
      chk("in_ready_run", 32'(in_ready), 32'd0);
      n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      chk("latency", n, 32'd4);
      for (int h = 0; h <= hold; h++) begin
         chk("sum",  32'(sum),  32'(es));
         chk("cout", 32'(cout), 32'(ec));
         chk("ovf",  32'(ovf),  32'(ev));
         chk("zero", 32'(zero), 32'(ez));
         chk("neg",  32'(neg),  32'(en));
         chk("in_ready_done", 32'(in_ready), 32'd0);
         chk("out_valid_hold", 32'(out_valid), 32'd1);
         if (h < hold) begin
            in_valid = (h == 0);
            a = 16'h0F0F; b = 16'h0101;
            tick();
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();                                     // result handshake edge
      out_ready = 1'b0;
      chk("out_valid_after_hs", 32'(out_valid), 32'd0);
      chk("in_ready_after_hs", 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic rop;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 1'b0; a = '0; b = '0;
      tick();
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_sum",       32'(sum),       32'd0);
      chk("rst_flags", {28'd0, cout, ovf, zero, neg}, 32'd0);
      rst = 1'b0;
      #1;
      chk("idle_in_ready", 32'(in_ready), 32'd1);

      // Test plan 1-4, plus wrap-around.
      do_op(16'h1234, 16'h4321, 1'b0, 0);
      do_op(16'h0005, 16'h0005, 1'b1, 0);
      do_op(16'h0003, 16'h0005, 1'b1, 0);
      do_op(16'h7FFF, 16'h0001, 1'b0, 0);
      do_op(16'h8000, 16'h0001, 1'b1, 0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 0);

      // Test plan 5: backpressure for 3 cycles, then an immediate new op.
      do_op(16'h00FF, 16'h0F01, 1'b0, 3);
      do_op(16'h1000, 16'h2000, 1'b1, 0);

      // Test plan 6: reset after two chunks of RUN.
      a = 16'h1111; b = 16'h2222; op = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_sum",       32'(sum),       32'd0);
      chk("midrst_flags", {28'd0, cout, ovf, zero, neg}, 32'd0);
      chk("midrst_in_ready",  32'(in_ready),  32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      tick();
      tick();
      chk("no_stale_result", 32'(out_valid), 32'd0);
      do_op(16'h0001, 16'h0001, 1'b0, 0);

      // Random operations with occasional backpressure.
      for (int i = 0; i < 40; i++) begin
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         rop = 1'($urandom);
         if (i % 8 == 0) rb = ra;                 // exercises zero on subtract
         do_op(ra, rb, rop, int'($urandom_range(0, 2)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
